// File: rtl/i2c_cfg_sequencer_if.sv
// Request/response bundle between the config sequencer and the I2C byte engine.
interface i2c_cfg_sequencer_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic       i2c_write;
    logic [7:0] i2c_data;
    logic       i2c_cmd_done;
    logic       i2c_cmd_status;

    modport master (
        output i2c_start,
        output i2c_stop,
        output i2c_write,
        output i2c_data,
        input  i2c_cmd_done,
        input  i2c_cmd_status
    );

    modport slave (
        input  i2c_start,
        input  i2c_stop,
        input  i2c_write,
        input  i2c_data,
        output i2c_cmd_done,
        output i2c_cmd_status
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// Loads a codec register table after power-up, one 3-byte I2C write per entry,
// with NACK retry, command timeout and a bus-free gap between transactions.
module i2c_cfg_sequencer #(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         NUM_REGS       = 10,
    parameter int         IDX_W          = 4,
    parameter int         MAX_RETRY      = 3,
    parameter int         GAP_CYCLES     = 64,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter bit         REVERSE_BITS   = 1'b1
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             go,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] fail_index,
    output logic [IDX_W-1:0] cfg_index,
    input  logic [15:0]      cfg_word,
    i2c_cfg_sequencer_if.master bus
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                             TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX) + 1;
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, START, ADDR, REGH,
        REGL, STOP, GAP, ERR_STOP, FINISH
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry;
    logic             pend;
    logic [15:0]      word;
    logic             start_q, stop_q, write_q;
    logic [7:0]       data_q;
    logic [7:0]       byte_n;
    logic             waiting, tmo, leaving, counting, last_idx;

    // The engine shifts data[0] first, so MSB-first bytes are mirrored.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return REVERSE_BITS ? r : b;
    endfunction

    assign last_idx = (cfg_index == IDX_LAST);
    assign leaving  = (state_n != state);
    assign counting = waiting || (state == GAP) || (state == FETCH);

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    assign bus.i2c_start = start_q;
    assign bus.i2c_stop  = stop_q;
    assign bus.i2c_write = write_q;
    assign bus.i2c_data  = data_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        waiting = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE:  if (go) state_n = FETCH;
            FETCH: if (cnt == CNT_ONE) state_n = START;
            START: begin
                waiting = !start_q;
                if (waiting && bus.i2c_cmd_done) state_n = ADDR;
            end
            ADDR, REGH, REGL: begin
                waiting = 1'b1;
                if (bus.i2c_cmd_done) begin
                    if (bus.i2c_cmd_status)
                        state_n = (retry < RTY_MAX) ? STOP : ERR_STOP;
                    else if (state == ADDR) state_n = REGH;
                    else if (state == REGH) state_n = REGL;
                    else                    state_n = STOP;
                end
            end
            STOP: begin
                waiting = !stop_q;
                if (waiting && bus.i2c_cmd_done) state_n = GAP;
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    if (pend)          state_n = START;
                    else if (last_idx) state_n = FINISH;
                    else               state_n = FETCH;
                end
            end
            ERR_STOP: begin
                waiting = !stop_q;
                if (waiting && bus.i2c_cmd_done) state_n = FINISH;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // A stalled engine aborts the sequence without a STOP.
        tmo = waiting && !bus.i2c_cmd_done && (cnt == TMO_LAST);
        if (tmo) state_n = FINISH;
    end

    always_comb begin
        case (state_n)
            ADDR:    byte_n = wire_order({DEV_ADDR, 1'b0});
            REGH:    byte_n = wire_order(word[15:8]);
            default: byte_n = wire_order(word[7:0]);
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            retry      <= '0;
            pend       <= 1'b0;
            word       <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            write_q    <= 1'b0;
            data_q     <= '0;
            cfg_index  <= '0;
            error      <= 1'b0;
            fail_index <= '0;
        end else begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            if (leaving)       cnt <= '0;
            else if (counting) cnt <= cnt + CNT_ONE;

            if (leaving) begin
                write_q <= 1'b0;
                case (state_n)
                    START:          start_q <= 1'b1;
                    STOP, ERR_STOP: stop_q  <= 1'b1;
                    ADDR, REGH, REGL: begin
                        write_q <= 1'b1;
                        data_q  <= byte_n;
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (go) begin
                        cfg_index  <= '0;
                        retry      <= '0;
                        pend       <= 1'b0;
                        error      <= 1'b0;
                        fail_index <= '0;
                    end
                end
                FETCH: if (leaving) word <= cfg_word;
                ADDR, REGH, REGL: begin
                    if (state_n == STOP && bus.i2c_cmd_status) begin
                        retry <= retry + RTY_W'(1);
                        pend  <= 1'b1;
                    end
                end
                GAP: begin
                    if (leaving) begin
                        if (pend) pend <= 1'b0;
                        else if (!last_idx) begin
                            cfg_index <= cfg_index + IDX_W'(1);
                            retry     <= '0;
                        end
                    end
                end
                ERR_STOP: begin
                    if (waiting && bus.i2c_cmd_done) begin
                        error      <= 1'b1;
                        fail_index <= cfg_index;
                    end
                end
                default: ;
            endcase

            if (tmo) begin
                error      <= 1'b1;
                fail_index <= cfg_index;
            end
        end
    end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Directed bench: behavioural byte engine plus a 2-entry sync table ROM.
module tb_i2c_cfg_sequencer;
    localparam int NREG = 2;
    localparam int GAP  = 8;
    localparam int TMO  = 32;
    localparam int RTY  = 3;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        go        = 1'b0;
    logic        busy, done, error;
    logic [3:0]  fail_index, cfg_index;
    logic [15:0] cfg_word  = 16'h0;

    i2c_cfg_sequencer_if bus ();

    i2c_cfg_sequencer #(
        .DEV_ADDR(7'h1A), .NUM_REGS(NREG), .IDX_W(4),
        .MAX_RETRY(RTY), .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO), .REVERSE_BITS(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .go(go),
        .busy(busy), .done(done), .error(error),
        .fail_index(fail_index), .cfg_index(cfg_index),
        .cfg_word(cfg_word), .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk)
        cfg_word <= (cfg_index == 4'd0) ? 16'h1E00 : 16'h0C12;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // wire-order (bit-reversed) bytes: 34->2C 1E->78 00->00 0C->30 12->48
    logic [7:0] e_ok  [6] = '{8'h2C, 8'h78, 8'h00, 8'h2C, 8'h30, 8'h48};
    logic [7:0] e_rty [8] = '{8'h2C, 8'h78, 8'h2C, 8'h78, 8'h00,
                              8'h2C, 8'h30, 8'h48};

    int n_start = 0, n_stop = 0, bpos = 0;
    int stop_cyc = 0, start_cyc = 0;
    bit have_stop = 0, nacked = 0;
    int nack_mode = 0;
    bit hang = 0;
    logic [7:0] bq [$];
    int gq [$];

    int n_done = 0, done_cyc = 0, n_excl = 0;
    always @(negedge sys_clk) begin
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (int'(bus.i2c_start) + int'(bus.i2c_stop) + int'(bus.i2c_write) > 1)
            n_excl <= n_excl + 1;
    end

    task automatic respond(input bit st);
        repeat (3) begin @(posedge sys_clk); #1; end
        bus.i2c_cmd_done   = 1'b1;
        bus.i2c_cmd_status = st;
        @(posedge sys_clk); #1;
        bus.i2c_cmd_done   = 1'b0;
        bus.i2c_cmd_status = 1'b0;
    endtask

    initial begin : engine
        bit nk;
        bus.i2c_cmd_done   = 1'b0;
        bus.i2c_cmd_status = 1'b0;
        @(posedge sys_clk); #1;
        forever begin
            if (bus.i2c_start) begin
                n_start++;
                start_cyc = cyc;
                bpos = 0;
                if (have_stop) gq.push_back(cyc - stop_cyc);
                have_stop = 0;
                if (hang) begin @(posedge sys_clk); #1; end
                else respond(1'b0);
            end else if (bus.i2c_stop) begin
                n_stop++;
                respond(1'b0);
                stop_cyc  = cyc;
                have_stop = 1;
            end else if (bus.i2c_write) begin
                bq.push_back(bus.i2c_data);
                nk = (nack_mode == 2 && bpos == 0) ||
                     (nack_mode == 1 && bpos == 1 && !nacked);
                if (nk && nack_mode == 1) nacked = 1;
                bpos++;
                respond(nk);
            end else begin
                if (!busy) begin
                    have_stop = 0;
                    nacked    = 0;
                end
                @(posedge sys_clk); #1;
            end
        end
    end

    int n_chk = 0, n_err = 0;
    int b0, s0, p0, g0, d0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input int idx,
                            input logic [7:0] exp);
        chk(tag, (idx < bq.size()) ? 32'(bq[idx]) : 32'hDEAD, 32'(exp));
    endtask

    task automatic snap();
        b0 = bq.size(); s0 = n_start; p0 = n_stop;
        g0 = gq.size(); d0 = n_done;
    endtask

    task automatic pulse_go();
        @(negedge sys_clk); go = 1'b1;
        @(negedge sys_clk); go = 1'b0;
    endtask

    task automatic wait_seq(input string tag, input int budget);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            @(negedge sys_clk); #1; k++;
        end
        chk(tag, (n_done != d0) ? 1 : 0, 1);
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   error, 0);
        chk({tag, "_fidx"},  fail_index, 0);
        chk({tag, "_cidx"},  cfg_index, 0);
        chk({tag, "_start"}, bus.i2c_start, 0);
        chk({tag, "_stop"},  bus.i2c_stop, 0);
        chk({tag, "_write"}, bus.i2c_write, 0);
        chk({tag, "_data"},  bus.i2c_data, 0);
    endtask

    initial begin : main
        bit found;
        int k;
        repeat (3) @(negedge sys_clk);
        chk_idle_out("rst");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // two entries, all ACK, with a stray go while busy
        snap();
        pulse_go();
        repeat (20) @(negedge sys_clk);
        chk("t1_busy_mid", busy, 1);
        pulse_go();
        wait_seq("t1_seq", 600);
        repeat (100) @(negedge sys_clk);
        chk("t1_ndone", n_done - d0, 1);
        chk("t1_nstart", n_start - s0, 2);
        chk("t1_nstop", n_stop - p0, 2);
        chk("t1_nbytes", bq.size() - b0, 6);
        for (int i = 0; i < 6; i++)
            chk_byte($sformatf("t1_b%0d", i), b0 + i, e_ok[i]);
        chk("t1_ngap", gq.size() - g0, 1);
        chk("t1_gap", (gq.size() > g0) ? gq[g0] : -1, GAP + 2);
        chk("t1_err", error, 0);
        chk("t1_busy", busy, 0);

        // NACK on the first REGH byte once
        nack_mode = 1;
        snap();
        pulse_go();
        wait_seq("t2_seq", 800);
        chk("t2_ndone", n_done - d0, 1);
        chk("t2_nstart", n_start - s0, 3);
        chk("t2_nstop", n_stop - p0, 3);
        chk("t2_nbytes", bq.size() - b0, 8);
        for (int i = 0; i < 8; i++)
            chk_byte($sformatf("t2_b%0d", i), b0 + i, e_rty[i]);
        chk("t2_gap_rty", (gq.size() > g0) ? gq[g0] : -1, GAP);
        chk("t2_gap_next", (gq.size() > g0 + 1) ? gq[g0+1] : -1, GAP + 2);
        chk("t2_err", error, 0);

        // NACK on ADDR every attempt
        nack_mode = 2;
        snap();
        pulse_go();
        wait_seq("t3_seq", 1000);
        chk("t3_ndone", n_done - d0, 1);
        chk("t3_nstart", n_start - s0, 4);
        chk("t3_nstop", n_stop - p0, 4);
        chk("t3_nbytes", bq.size() - b0, 4);
        for (int i = 0; i < 4; i++)
            chk_byte($sformatf("t3_b%0d", i), b0 + i, 8'h2C);
        chk("t3_err", error, 1);
        chk("t3_fidx", fail_index, 0);
        chk("t3_busy", busy, 0);

        // engine never completes the START
        nack_mode = 0;
        hang = 1;
        snap();
        pulse_go();
        wait_seq("t4_seq", 300);
        hang = 0;
        chk("t4_ndone", n_done - d0, 1);
        chk("t4_nstart", n_start - s0, 1);
        chk("t4_nstop", n_stop - p0, 0);
        chk("t4_latency", done_cyc - start_cyc, TMO + 1);
        chk("t4_err", error, 1);
        chk("t4_fidx", fail_index, 0);
        chk("t4_busy", busy, 0);

        // new go clears error and restarts from entry 0
        snap();
        pulse_go();
        chk("t5_err_clr", error, 0);
        chk("t5_busy", busy, 1);
        chk("t5_cidx", cfg_index, 0);
        wait_seq("t5_seq", 600);
        chk("t5_nbytes", bq.size() - b0, 6);
        for (int i = 0; i < 6; i++)
            chk_byte($sformatf("t5_b%0d", i), b0 + i, e_ok[i]);
        chk("t5_err", error, 0);

        // reset while REGL of entry 1 is in flight
        snap();
        pulse_go();
        found = 0;
        k = 0;
        while (!found && k < 400) begin
            @(negedge sys_clk); #1; k++;
            if (n_start - s0 == 2 && bpos == 3 && bus.i2c_write) found = 1;
        end
        chk("t6_reach", found, 1);
        chk("t6_pre_cidx", cfg_index, 1);
        chk("t6_pre_data", bus.i2c_data, 8'h48);
        sys_rst_n = 1'b0;
        #1;
        chk_idle_out("t6_rst");
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        snap();
        pulse_go();
        chk("t6_cidx", cfg_index, 0);
        wait_seq("t6_seq", 600);
        chk("t6_nbytes", bq.size() - b0, 6);
        for (int i = 0; i < 6; i++)
            chk_byte($sformatf("t6_b%0d", i), b0 + i, e_ok[i]);
        chk("t6_err", error, 0);

        chk("excl", n_excl, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Drives the existing I2C byte engine (start/stop/write/data in, cmd_done/cmd_status out) to load a register table into the audio codec after power-up.
- Each table entry is sent as one 3-byte I2C write transaction: START, device address + W, high byte, low byte, STOP.
- Handles NACK retry, command timeout and inter-transaction bus-free gap.
- Sits between the top-level init logic and the byte engine.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit codec slave address.
- NUM_REGS, 10, table entries to send; must be at least 1.
- IDX_W, 4, width of cfg_index; 2^IDX_W must be at least NUM_REGS.
- MAX_RETRY, 3, retries per entry after NACK; total attempts = MAX_RETRY+1.
- GAP_CYCLES, 64, sys_clk cycles of idle bus between a STOP and the next START.
- TIMEOUT_CYCLES, 4096, maximum sys_clk cycles waiting for i2c_cmd_done.
- REVERSE_BITS, 1, when 1 i2c_data is bit-reversed, because the byte engine shifts data[0] first.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle pulse that starts the table sequence.
- busy  out  1  high from the go acceptance through the DONE/ERROR entry.
- done  out  1  one-cycle pulse when the sequence ends, on success or error.
- error  out  1  level; set on failure, cleared by the next accepted go.
- fail_index  out  IDX_W  entry that failed; valid while error=1.
- cfg_index  out  IDX_W  table address for the external sync ROM.
- cfg_word  in  16  table data, valid 1 cycle after cfg_index changes.
- i2c_start  out  1  one-cycle START request.
- i2c_stop  out  1  one-cycle STOP request.
- i2c_write  out  1  level byte-write request, held until i2c_cmd_done.
- i2c_data  out  8  byte to transmit, stable while i2c_write=1.
- i2c_cmd_done  in  1  engine command-complete pulse.
- i2c_cmd_status  in  1  after a write: 0 = ACK, 1 = NACK.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, retry and timeout counters 0.
- States: IDLE, FETCH, START, ADDR, REGH, REGL, STOP, GAP, ERR_STOP, FINISH.
- IDLE: go=1 → cfg_index=0, retry=0, error=0, busy=1, go to FETCH. go is ignored whenever busy=1.
- FETCH: wait 1 cycle, then latch cfg_word into an internal 16-bit register and go to START.
- START: pulse i2c_start for 1 cycle, then wait for i2c_cmd_done, then go to ADDR.
- ADDR, REGH, REGL:
  - Register i2c_data and set i2c_write=1 on state entry.
  - Bytes are, in order: {DEV_ADDR,1'b0}, word[15:8], word[7:0]; bit-reversed if REVERSE_BITS=1.
  - i2c_write clears on the same edge that samples i2c_cmd_done=1.
  - i2c_cmd_status is sampled on that same edge.
  - ACK → next byte state; after REGL, go to STOP.
  - NACK → if retry<MAX_RETRY: retry+1, go to STOP, and after GAP re-enter START with the same entry (no refetch). Otherwise go to ERR_STOP.
- STOP: pulse i2c_stop for 1 cycle, wait for i2c_cmd_done, then go to GAP.
- GAP: count GAP_CYCLES, then:
  - pending retry → START;
  - cfg_index==NUM_REGS-1 → FINISH;
  - otherwise cfg_index+1, retry=0, FETCH.
- ERR_STOP: pulse i2c_stop, wait for i2c_cmd_done, set error=1 and fail_index=cfg_index, go to FINISH.
- FINISH: done=1 for 1 cycle, busy=0, return to IDLE. error holds.
- Timeout:
  - The counter resets on entry to every wait and increments each cycle while waiting for i2c_cmd_done.
  - Reaching TIMEOUT_CYCLES-1 is fatal with no retry: clear i2c_write, set error and fail_index, go directly to FINISH without issuing STOP.
- i2c_start, i2c_stop and i2c_write are mutually exclusive; at most one is high in any cycle.
- An i2c_cmd_done that arrives while the block is not waiting is ignored.
- sys_rst_n low mid-transaction: all requests drop immediately and the block returns to IDLE. Bus recovery is the engine's concern.

Test Plan:
- NUM_REGS=2, cfg_word 16'h1E00 then 16'h0C12, engine model always ACKs, go pulse → two transactions with bytes 34,1E,00 and 34,0C,12 (MSB-first values); done pulse, error=0, ≥GAP_CYCLES idle between the first STOP done and the second START.
- Model NACKs the first REGH byte once → STOP, gap, full retry of entry 0 with identical bytes, then success; done, error=0.
- Model NACKs the ADDR byte every time (MAX_RETRY=3) → exactly 4 attempts, STOP issued, error=1, fail_index=0, done pulse, busy=0.
- Model never returns i2c_cmd_done after START, TIMEOUT_CYCLES=32 → after 32 cycles done pulse, error=1, no i2c_stop issued.
- go pulsed again while busy=1 → ignored; sequence completes once. A later go clears error and restarts from index 0.
- sys_rst_n asserted while i2c_write=1 during REGL → all outputs 0 asynchronously. After release, go restarts from cfg_index=0.
